// File: rtl/rle_pkg.sv
// rle_pkg: shared definitions for the RLE compressor / decoder pair.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: FSM state enum, entry/word geometry, entry field positions and
// field-extraction helpers for one 16-bit {byte, count} entry.
package rle_pkg;

   localparam int ENTRY_W    = 16;
   localparam int WORD_BYTES = 4;

   // Field positions inside one entry: {byte[15:8], count[7:0]}
   localparam int BYTE_MSB  = 15;
   localparam int BYTE_LSB  = 8;
   localparam int COUNT_MSB = 7;
   localparam int COUNT_LSB = 0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_REQ = 3'd1,
      RD_LAT = 3'd2,
      DECODE = 3'd3,
      WRITE  = 3'd4,
      FLUSH  = 3'd5,
      FINISH = 3'd6
   } rle_state_t;

   function automatic logic [7:0] entry_byte(input logic [ENTRY_W-1:0] e);
      return e[BYTE_MSB:BYTE_LSB];
   endfunction

   function automatic logic [7:0] entry_count(input logic [ENTRY_W-1:0] e);
      return e[COUNT_MSB:COUNT_LSB];
   endfunction

endpackage

// File: rtl/rle_byte_packer.sv
// rle_byte_packer: assembles bytes little-endian into one 32-bit word.
// Latency: a push/fill4 is visible on word/full/empty the cycle after.
// Backpressure: none; pushes while full are dropped, caller must drain via clear.
// Ports: clk, nreset (async active-low); push + data_byte append one byte,
// fill4 loads four copies of data_byte, clear empties the word (priority
// clear > fill4 > push); word (unused upper bytes read as zero), full, empty.
module rle_byte_packer
   import rle_pkg::*;
(
   input  logic        clk,
   input  logic        nreset,
   input  logic        push,
   input  logic [7:0]  data_byte,
   input  logic        fill4,
   input  logic        clear,
   output logic [31:0] word,
   output logic        full,
   output logic        empty
);

   logic [2:0] level;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         word  <= '0;
         level <= '0;
      end else if (clear) begin
         // Zeroing here keeps unused upper bytes zero for a partial final word
         word  <= '0;
         level <= '0;
      end else if (fill4) begin
         word  <= {WORD_BYTES{data_byte}};
         level <= 3'(WORD_BYTES);
      end else if (push && !full) begin
         word[{level[1:0], 3'b000} +: 8] <= data_byte;
         level <= level + 3'd1;
      end
   end

   assign full  = (level == 3'(WORD_BYTES));
   assign empty = (level == 3'd0);

endmodule

// File: rtl/rle_decode.sv
// rle_decode: expands a {byte,count} RLE frame from port-A memory back into plaintext.
// Latency: 2 cycles per word fetch, 1 per emitted byte or pad entry, 1 per word write.
// Backpressure: none; runs to completion once started, start ignored until IDLE.
// Ports: clk, nreset (async active-low); start, rle_addr, rle_size,
// message_addr control a run; message_size counts decoded bytes, done flags
// completion; port_A_* is the single-port memory interface (read data one
// cycle after address).
// Config: define RLE_DECODE_FAST_FILL_EN to write whole words of a run of
// length >= 4 in one cycle when the pack buffer is empty.
module rle_decode
   import rle_pkg::*;
(
   input  logic        clk,
   input  logic        nreset,
   input  logic        start,
   input  logic [31:0] rle_addr,
   input  logic [31:0] rle_size,
   input  logic [31:0] message_addr,
   output logic [31:0] message_size,
   output logic        done,
   output logic        port_A_clk,
   output logic [15:0] port_A_addr,
   output logic        port_A_we,
   output logic [31:0] port_A_data_in,
   input  logic [31:0] port_A_data_out
);

   rle_state_t  state;
   logic [15:0] read_addr;
   logic [15:0] write_addr;
   logic [31:0] rle_size_q;
   logic [29:0] words_read;
   logic [31:0] entry_q;
   logic        entry_sel;
   logic [7:0]  cnt_q;
   logic        word_done;

   logic [15:0] cur_entry;
   logic [7:0]  cur_byte;
   logic        fast_go;
   logic        emit;
   logic        push;
   logic [2:0]  step;
   logic        exhaust;
   logic        goes_full;
   logic        last_word;
   logic        pk_clear;
   logic [31:0] pk_word;
   logic        pk_full;
   logic        pk_empty;
   logic        unused_hi;

   assign port_A_clk = clk;
   assign unused_hi  = ^{rle_addr[31:16], message_addr[31:16], pk_full};

   assign cur_entry = entry_sel ? entry_q[31:16] : entry_q[15:0];
   assign cur_byte  = entry_byte(cur_entry);
   assign last_word = ({words_read, 2'b00} >= rle_size_q);

   always_comb begin
      fast_go = 1'b0;
`ifdef RLE_DECODE_FAST_FILL_EN
      fast_go = (state == DECODE) && pk_empty && (cnt_q >= 8'd4);
`else
      fast_go = 1'b0;
`endif
      emit    = (state == DECODE) && (cnt_q != 8'd0);
      push    = emit && !fast_go;
      step    = fast_go ? 3'd4 : 3'd1;
      // A zero count (pad, or already drained) and the final emission both
      // end the current entry in this cycle, so no extra cycle is spent.
      exhaust = (cnt_q == 8'd0) || (cnt_q == {5'd0, step});
      // Buffer fill level always equals message_size mod 4: bytes only enter
      // the buffer as they are counted and every full word is written out.
      goes_full = fast_go || (push && (message_size[1:0] == 2'd3));
      pk_clear  = ((state == IDLE) && start) || (state == WRITE) || (state == FLUSH);
   end

   always_comb begin
      port_A_we      = (state == WRITE) || ((state == FLUSH) && !pk_empty);
      port_A_addr    = port_A_we ? write_addr : read_addr;
      port_A_data_in = port_A_we ? pk_word : 32'd0;
   end

   rle_byte_packer u_packer (
      .clk       (clk),
      .nreset    (nreset),
      .push      (push),
      .data_byte (cur_byte),
      .fill4     (fast_go),
      .clear     (pk_clear),
      .word      (pk_word),
      .full      (pk_full),
      .empty     (pk_empty)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state        <= IDLE;
         read_addr    <= '0;
         write_addr   <= '0;
         rle_size_q   <= '0;
         words_read   <= '0;
         entry_q      <= '0;
         entry_sel    <= 1'b0;
         cnt_q        <= '0;
         word_done    <= 1'b0;
         message_size <= '0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  read_addr    <= rle_addr[15:0];
                  write_addr   <= message_addr[15:0];
                  rle_size_q   <= rle_size;
                  words_read   <= '0;
                  entry_sel    <= 1'b0;
                  cnt_q        <= '0;
                  word_done    <= 1'b0;
                  message_size <= '0;
                  done         <= 1'b0;
                  state        <= (rle_size == 32'd0) ? FINISH : RD_REQ;
               end
            end

            RD_REQ: begin
               read_addr  <= read_addr + 16'(WORD_BYTES);
               words_read <= words_read + 30'd1;
               state      <= RD_LAT;
            end

            RD_LAT: begin
               entry_q   <= port_A_data_out;
               entry_sel <= 1'b0;
               cnt_q     <= entry_count(port_A_data_out[15:0]);
               word_done <= 1'b0;
               state     <= DECODE;
            end

            DECODE: begin
               if (emit) begin
                  cnt_q        <= cnt_q - {5'd0, step};
                  message_size <= message_size + {29'd0, step};
               end
               if (exhaust) begin
                  if (!entry_sel) begin
                     entry_sel <= 1'b1;
                     cnt_q     <= entry_count(entry_q[31:16]);
                  end else begin
                     word_done <= 1'b1;
                  end
               end
               // A full buffer is drained first; WRITE resumes the word afterwards
               if (goes_full)
                  state <= WRITE;
               else if (exhaust && entry_sel)
                  state <= last_word ? FLUSH : RD_REQ;
               else
                  state <= DECODE;
            end

            WRITE: begin
               write_addr <= write_addr + 16'(WORD_BYTES);
               if (word_done)
                  state <= last_word ? FLUSH : RD_REQ;
               else
                  state <= DECODE;
            end

            FLUSH: begin
               if (!pk_empty)
                  write_addr <= write_addr + 16'(WORD_BYTES);
               state <= FINISH;
            end

            FINISH: begin
               done  <= 1'b1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rle_decode.sv
// tb_rle_decode: directed and randomized frames against a byte-queue reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_rle_decode;
   import rle_pkg::*;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] rle_addr = '0;
   logic [31:0] rle_size = '0;
   logic [31:0] message_addr = '0;
   logic [31:0] message_size;
   logic        done;
   logic        port_A_clk;
   logic [15:0] port_A_addr;
   logic        port_A_we;
   logic [31:0] port_A_data_in;
   logic [31:0] port_A_data_out;

   rle_decode dut (
      .clk             (clk),
      .nreset          (nreset),
      .start           (start),
      .rle_addr        (rle_addr),
      .rle_size        (rle_size),
      .message_addr    (message_addr),
      .message_size    (message_size),
      .done            (done),
      .port_A_clk      (port_A_clk),
      .port_A_addr     (port_A_addr),
      .port_A_we       (port_A_we),
      .port_A_data_in  (port_A_data_in),
      .port_A_data_out (port_A_data_out)
   );

   always #5 clk = ~clk;

   // Memory model: synchronous single port, read data one cycle after address.
   logic [31:0] mem [0:16383];
   logic        tb_wr = 1'b0;
   logic [15:0] tb_addr = '0;
   logic [31:0] tb_data = '0;

   always @(posedge clk) begin
      if (tb_wr)
         mem[tb_addr[15:2]] <= tb_data;
      else if (port_A_we)
         mem[port_A_addr[15:2]] <= port_A_data_in;
      port_A_data_out <= mem[port_A_addr[15:2]];
   end

   // Write monitor, sampled away from the active edge
   int wr_total = 0;
   int consec_total = 0;
   int last_gap = 0;
   int cyc = 0;
   int last_wr_cyc = 0;
   logic prev_we = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (port_A_we === 1'b1) begin
         wr_total = wr_total + 1;
         if (prev_we) consec_total = consec_total + 1;
         last_gap = cyc - last_wr_cyc;
         last_wr_cyc = cyc;
      end
      prev_we = (port_A_we === 1'b1);
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mem_write(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      tb_wr = 1'b1; tb_addr = a; tb_data = d;
      @(negedge clk);
      tb_wr = 1'b0;
   endtask

   // Reference model: expand entries to a byte stream, then pack words
   logic [31:0] frame_q[$];
   logic [7:0]  exp_bytes[$];
   int          done_lat;

   function automatic void build_model();
      logic [15:0] ent;
      exp_bytes = {};
      foreach (frame_q[i]) begin
         for (int e = 0; e < 2; e++) begin
            ent = frame_q[i][16*e +: 16];
            for (int k = 0; k < int'(ent[7:0]); k++)
               exp_bytes.push_back(ent[15:8]);
         end
      end
   endfunction

   function automatic logic [31:0] exp_word(input int j);
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < 4; b++)
         if (4*j + b < exp_bytes.size())
            w[8*b +: 8] = exp_bytes[4*j + b];
      return w;
   endfunction

   task automatic run_frame(input string tag, input logic [15:0] raddr,
                            input logic [15:0] maddr, input bit poke);
      int nw, wr0, cs0, n;
      build_model();
      nw = (exp_bytes.size() + 3) / 4;
      foreach (frame_q[i]) mem_write(raddr + 16'(4*i), frame_q[i]);
      for (int i = 0; i <= nw; i++) mem_write(maddr + 16'(4*i), 32'hDEAD_BEEF);
      wr0 = wr_total;
      cs0 = consec_total;
      @(negedge clk);
      start = 1'b1;
      rle_addr = {16'hABCD, raddr};
      rle_size = 32'(4 * frame_q.size());
      message_addr = {16'h1234, maddr};
      @(negedge clk);
      start = 1'b0;
      check({tag, " done_cleared"}, {31'd0, done}, 32'd0);
      n = 0;
      while (done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
         if (poke && n == 3) begin
            start = 1'b1; rle_addr = 32'h0000_3000; message_addr = 32'h0000_3800;
         end
         if (poke && n == 4) start = 1'b0;
      end
      done_lat = n;
      check({tag, " done"}, {31'd0, done}, 32'd1);
      check({tag, " message_size"}, message_size, 32'(exp_bytes.size()));
      check({tag, " writes"}, 32'(wr_total - wr0), 32'(nw));
      check({tag, " consecutive_we"}, 32'(consec_total - cs0), 32'd0);
      for (int j = 0; j < nw; j++)
         check($sformatf("%s word%0d", tag, j), mem[(maddr >> 2) + 16'(j)], exp_word(j));
      check({tag, " past_end"}, mem[(maddr >> 2) + 16'(nw)], 32'hDEAD_BEEF);
   endtask

   initial begin
      int nwords, cnt, tmo;
      logic [7:0] b0, c0, b1, c1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst message_size", message_size, 32'd0);
      check("rst we", {31'd0, port_A_we}, 32'd0);
      check("rst data_in", port_A_data_in, 32'd0);
      check("rst addr", {16'd0, port_A_addr}, 32'd0);
      nreset = 1'b1;
      @(negedge clk);

      // Basic run
      frame_q = {32'h4202_4103};
      run_frame("basic", 16'h0100, 16'h0200, 1'b0);
      check("basic w0 const", mem[16'h0200 >> 2], 32'h4241_4141);
      check("basic w1 const", mem[16'h0204 >> 2], 32'h0000_0042);
      check("basic size const", message_size, 32'd5);

      // Pad entry
      frame_q = {32'h0000_7A01};
      run_frame("pad", 16'h0300, 16'h0400, 1'b0);
      check("pad w0 const", mem[16'h0400 >> 2], 32'h0000_007A);

      // Long run, with an ignored start pulse mid-frame
      frame_q = {32'h0000_FFFF};
      run_frame("long", 16'h0500, 16'h0600, 1'b1);
      check("long last const", mem[(16'h0600 >> 2) + 16'd63], 32'h00FF_FFFF);

      // Fast fill run: gap between the two full-word writes
      frame_q = {32'h0000_5508};
      run_frame("fill", 16'h0800, 16'h0900, 1'b0);
`ifdef RLE_DECODE_FAST_FILL_EN
      check("fill gap", 32'(last_gap), 32'd2);
`else
      check("fill gap", 32'(last_gap), 32'd5);
`endif

      // Empty frame: done two cycles after start, nothing written
      frame_q = {};
      run_frame("empty", 16'h0A00, 16'h0B00, 1'b0);
      check("empty latency", 32'(done_lat), 32'd1);

      // Pad-only frame
      frame_q = {32'h0000_0000, 32'h1100_2200};
      run_frame("padonly", 16'h0C00, 16'h0D00, 1'b0);

      // Reset during WRITE
      frame_q = {32'h0000_FFFF};
      foreach (frame_q[i]) mem_write(16'h0E00, frame_q[i]);
      @(negedge clk);
      start = 1'b1; rle_addr = 32'h0E00; rle_size = 32'd4; message_addr = 32'h0F00;
      @(negedge clk);
      start = 1'b0;
      tmo = 0;
      while (port_A_we !== 1'b1 && tmo < 200) begin
         @(negedge clk);
         tmo++;
      end
      check("mid reached write", {31'd0, port_A_we}, 32'd1);
      nreset = 1'b0;
      #1;
      check("mid we", {31'd0, port_A_we}, 32'd0);
      check("mid done", {31'd0, done}, 32'd0);
      check("mid message_size", message_size, 32'd0);
      check("mid state", 32'(dut.state), 32'(IDLE));
      @(negedge clk);
      nreset = 1'b1;
      frame_q = {32'h4202_4103, 32'h0001_3302};
      run_frame("after_rst", 16'h1000, 16'h1100, 1'b0);

      // Randomized frames
      for (int f = 0; f < 8; f++) begin
         frame_q = {};
         nwords = $urandom_range(1, 4);
         for (int i = 0; i < nwords; i++) begin
            b0 = 8'($urandom); b1 = 8'($urandom);
            cnt = $urandom_range(0, 3);
            c0 = (cnt == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            cnt = $urandom_range(0, 3);
            c1 = (cnt == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            frame_q.push_back({b1, c1, b0, c0});
         end
         run_frame($sformatf("rand%0d", f), 16'h2000 + 16'(f * 16'h0100),
                   16'h8000 + 16'(f * 16'h0200), 1'(f % 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
